// File: rtl/inst_loader_if.sv
// inst_loader_if: byte-stream input and instruction-memory write port of the program loader
interface inst_loader_if #(parameter int ADDR_W = 5);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    modport master (output rx_valid, rx_data, input rx_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (input rx_valid, rx_data, output rx_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/inst_loader.sv
// inst_loader: assembles a big-endian byte stream into instruction-memory words, holding the core in reset until done
// LOADER_CHECKSUM_EN adds a trailing XOR checksum byte with CHECK/ERR states.
module inst_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    inst_loader_if.slave bus,
    output logic         cpu_rst_n_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         error_o
);
    localparam int CW = $clog2(DEPTH);
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, DONE} state_t;
`endif
    state_t            state_q, state_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rdy, we, xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif
    // ready depends only on registered state, never on rx_valid
    assign rdy  = (state_q == COUNT) || (state_q == DATA)
`ifdef LOADER_CHECKSUM_EN
                || (state_q == CHECK)
`endif
                ;
    assign we   = state_q == WRITE;
    assign xfer = bus.rx_valid & rdy;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: if (start_i) begin
                state_d = COUNT;
`ifdef LOADER_CHECKSUM_EN
                csum_d  = '0;
`endif
            end
            COUNT: if (xfer) begin
                wcnt_d  = bus.rx_data[CW-1:0];
                addr_d  = '0;
                bcnt_d  = '0;
                state_d = DATA;
`ifdef LOADER_CHECKSUM_EN
                csum_d  = csum_q ^ bus.rx_data;
`endif
            end
            DATA: if (xfer) begin
                wdata_d = {wdata_q[23:0], bus.rx_data};
                bcnt_d  = bcnt_q + 2'd1;
                state_d = (bcnt_q == 2'd3) ? WRITE : DATA;
`ifdef LOADER_CHECKSUM_EN
                csum_d  = csum_q ^ bus.rx_data;
`endif
            end
            WRITE: if (wcnt_q == '0) begin
`ifdef LOADER_CHECKSUM_EN
                state_d = CHECK;
`else
                state_d = DONE;
`endif
            end else begin
                wcnt_d  = wcnt_q - 1'b1;
                addr_d  = addr_q + 1'b1;
                state_d = DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: if (xfer) state_d = (bus.rx_data == csum_q) ? DONE : ERR;
            DONE, ERR: if (start_i) begin
                state_d = COUNT;
                csum_d  = '0;
            end
`else
            DONE: if (start_i) state_d = COUNT;
`endif
            default: state_d = IDLE;
        endcase
    end
    assign bus.rx_ready  = rdy;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_rst_n_o   = state_q == DONE;
    assign busy_o        = rdy | we;
    assign done_o        = state_q == DONE;
`ifdef LOADER_CHECKSUM_EN
    assign error_o       = state_q == ERR;
`else
    assign error_o       = 1'b0;
`endif
endmodule
